// File: rtl/uart_prog_loader.sv
// UART program loader: receives framed program images over an 8N1 UART,
// streams each assembled word to program memory with a one-cycle strobe,
// and answers each frame with an ACK (0x06) or NAK (0x15) byte.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 16,
   parameter int TIMEOUT_CLKS = 2_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              tx,
   output logic [ADDR_W-1:0] PADD,
   output logic [DATA_W-1:0] DOUT,
   output logic              wren,
   output logic              busy,
   output logic              err
);
   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 2);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CLKS);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {ST_SYNC, ST_CNT, ST_ADDH, ST_ADDL, ST_DATA, ST_CSUM, ST_TXACK} state_t;

   logic             rx_meta_r, rx_sync_r, rx_prev_r;
   rx_state_t        rx_state_r;
   logic [CNT_W-1:0] rx_cnt_r;
   logic [2:0]       rx_bit_r;
   logic [7:0]       rx_shift_r, rx_byte_r;
   logic             rx_valid_r, rx_ferr_r;

   state_t           state_r;
   logic [7:0]       count_r, sum_r, addr_hi_r;
   logic [2:0]       byte_idx_r;
   logic [DATA_W-1:0] data_r, word_s;
   logic [TO_W-1:0]  gap_r;
   logic [8:0]       tx_shift_r;
   logic [CNT_W-1:0] tx_cnt_r;
   logic [3:0]       tx_bit_r;
   logic             active_s, abort_s;

   // Two-flop synchroniser for rx plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Byte receiver: mid-bit sampling, emits a one-cycle valid or framing-error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= '0;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
         rx_byte_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         rx_ferr_r  <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         rx_ferr_r  <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               if (rx_prev_r && !rx_sync_r) begin
                  rx_state_r <= RX_START;
                  rx_cnt_r   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt_r == HALF_M1) begin
                  rx_cnt_r <= '0;
                  // A glitch that is high again at mid-start is not a start bit.
                  if (rx_sync_r) begin
                     rx_state_r <= RX_IDLE;
                  end else begin
                     rx_state_r <= RX_BITS;
                     rx_bit_r   <= 3'd0;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_W'(1);
               end
            end
            RX_BITS: begin
               if (rx_cnt_r == FULL_M1) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     rx_bit_r <= rx_bit_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == FULL_M1) begin
                  rx_cnt_r   <= '0;
                  rx_state_r <= RX_IDLE;
                  if (rx_sync_r) begin
                     rx_valid_r <= 1'b1;
                     rx_byte_r  <= rx_shift_r;
                  end else begin
                     rx_ferr_r <= 1'b1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_W'(1);
               end
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // Frame-receiving states, and the abort condition (framing error or idle gap too long).
   always_comb begin
      active_s = 1'b0;
      if ((state_r == ST_CNT) || (state_r == ST_ADDH) || (state_r == ST_ADDL) ||
          (state_r == ST_DATA) || (state_r == ST_CSUM)) begin
         active_s = 1'b1;
      end else begin
         active_s = 1'b0;
      end
      abort_s = active_s && (rx_ferr_r || (gap_r > TO_LIM));
   end

   // Current word with the just-received byte dropped into its little-endian slot.
   always_comb begin
      word_s = data_r;
      for (int i = 0; i < BPW; i++) begin
         if (byte_idx_r == 3'(i)) begin
            word_s[i*8 +: 8] = rx_byte_r;
         end else begin
            word_s[i*8 +: 8] = data_r[i*8 +: 8];
         end
      end
   end

   // Frame FSM with registered memory-write, status and UART transmit outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_SYNC;
         tx         <= 1'b1;
         wren       <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         PADD       <= '0;
         DOUT       <= '0;
         data_r     <= '0;
         count_r    <= 8'h00;
         sum_r      <= 8'h00;
         addr_hi_r  <= 8'h00;
         byte_idx_r <= 3'd0;
         gap_r      <= '0;
         tx_shift_r <= 9'h1FF;
         tx_cnt_r   <= '0;
         tx_bit_r   <= 4'd0;
      end else begin
         wren <= 1'b0;
         if (wren) begin
            PADD <= PADD + ADDR_W'(1);
         end
         if (rx_valid_r || !active_s) begin
            gap_r <= '0;
         end else begin
            gap_r <= gap_r + TO_W'(1);
         end
         if (abort_s) begin
            state_r <= ST_SYNC;
            busy    <= 1'b0;
            err     <= 1'b1;
         end else begin
            case (state_r)
               ST_SYNC: begin
                  if (rx_valid_r && (rx_byte_r == SYNC_BYTE)) begin
                     state_r <= ST_CNT;
                     busy    <= 1'b1;
                     err     <= 1'b0;
                     sum_r   <= 8'h00;
                  end
               end
               ST_CNT: begin
                  if (rx_valid_r) begin
                     count_r <= rx_byte_r;
                     sum_r   <= sum_r + rx_byte_r;
                     state_r <= ST_ADDH;
                  end
               end
               ST_ADDH: begin
                  if (rx_valid_r) begin
                     addr_hi_r <= rx_byte_r;
                     sum_r     <= sum_r + rx_byte_r;
                     state_r   <= ST_ADDL;
                  end
               end
               ST_ADDL: begin
                  if (rx_valid_r) begin
                     PADD       <= ADDR_W'({addr_hi_r, rx_byte_r});
                     sum_r      <= sum_r + rx_byte_r;
                     byte_idx_r <= 3'd0;
                     state_r    <= (count_r == 8'h00) ? ST_CSUM : ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (rx_valid_r) begin
                     sum_r  <= sum_r + rx_byte_r;
                     data_r <= word_s;
                     if (byte_idx_r == 3'(BPW - 1)) begin
                        byte_idx_r <= 3'd0;
                        DOUT       <= word_s;
                        wren       <= 1'b1;
                        count_r    <= count_r - 8'd1;
                        if (count_r == 8'd1) begin
                           state_r <= ST_CSUM;
                        end
                     end else begin
                        byte_idx_r <= byte_idx_r + 3'd1;
                     end
                  end
               end
               ST_CSUM: begin
                  if (rx_valid_r) begin
                     // Start bit goes out now; shift register holds data then stop.
                     tx         <= 1'b0;
                     tx_shift_r <= {1'b1, (rx_byte_r == sum_r) ? ACK_BYTE : NAK_BYTE};
                     tx_cnt_r   <= '0;
                     tx_bit_r   <= 4'd0;
                     err        <= (rx_byte_r != sum_r);
                     state_r    <= ST_TXACK;
                  end
               end
               ST_TXACK: begin
                  if (tx_cnt_r == FULL_M1) begin
                     tx_cnt_r <= '0;
                     if (tx_bit_r == 4'd9) begin
                        state_r <= ST_SYNC;
                        busy    <= 1'b0;
                     end else begin
                        tx         <= tx_shift_r[0];
                        tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                        tx_bit_r   <= tx_bit_r + 4'd1;
                     end
                  end else begin
                     tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                  end
               end
               default: begin
                  state_r <= ST_SYNC;
                  busy    <= 1'b0;
                  tx      <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: one 16-bit-address instance and one
// 8-bit-address instance (for address wrap). Expected writes and TX bytes are
// queued by the stimulus; monitors pop and compare as the DUTs produce them.
module tb_uart_prog_loader;
   localparam int CPB = 8;
   localparam int TO  = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_a, rx_b;
   logic        tx_a, tx_b;
   logic [15:0] padd_a;
   logic [7:0]  padd_b;
   logic [15:0] dout_a, dout_b;
   logic        wren_a, wren_b, busy_a, busy_b, err_a, err_b;

   int total = 0;
   int bad   = 0;
   logic [32:0] wr_q[$];     // {dut, addr, data}
   logic [8:0]  tx_q[$];     // {dut, byte}
   logic [7:0]  frame_q[$];

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .DATA_W(16), .ADDR_W(16), .TIMEOUT_CLKS(TO)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .PADD(padd_a), .DOUT(dout_a),
      .wren(wren_a), .busy(busy_a), .err(err_a));

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .DATA_W(16), .ADDR_W(8), .TIMEOUT_CLKS(TO)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .PADD(padd_b), .DOUT(dout_b),
      .wren(wren_b), .busy(busy_b), .err(err_b));

   always #5 clk = ~clk;

   function automatic logic get_tx(input int k);
      return (k == 0) ? tx_a : tx_b;
   endfunction

   function automatic logic get_busy(input int k);
      return (k == 0) ? busy_a : busy_b;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_wr(input int k, input logic [15:0] a, input logic [15:0] d);
      logic [32:0] e;
      total++;
      if (wr_q.size() == 0) begin
         bad++;
         $display("FAIL write dut=%0d: got addr=%h data=%h, expected no write", k, a, d);
      end else begin
         e = wr_q.pop_front();
         if (e !== {(k == 1), a, d}) begin
            bad++;
            $display("FAIL write dut=%0d: got addr=%h data=%h, expected dut=%0d addr=%h data=%h",
                     k, a, d, e[32], e[31:16], e[15:0]);
         end
      end
   endtask

   task automatic check_tx(input int k, input logic [7:0] b, input logic stop_bit);
      logic [8:0] e;
      total++;
      if (tx_q.size() == 0) begin
         bad++;
         $display("FAIL tx dut=%0d: got byte %h, expected no transmission", k, b);
      end else begin
         e = tx_q.pop_front();
         if ((e !== {(k == 1), b}) || (stop_bit !== 1'b1)) begin
            bad++;
            $display("FAIL tx dut=%0d: got byte %h stop=%b, expected dut=%0d byte %h stop=1",
                     k, b, stop_bit, e[8], e[7:0]);
         end
      end
   endtask

   // Write monitor: wren is exactly one cycle wide, so each falling edge sees it once.
   always @(negedge clk) begin
      if (wren_a) check_wr(0, padd_a, dout_a);
      if (wren_b) check_wr(1, {8'h00, padd_b}, dout_b);
   end

   // TX monitor: decode any 8N1 byte on the DUT's tx line.
   task automatic tx_mon(input int k);
      logic [7:0] b;
      logic       stop_bit;
      forever begin
         @(negedge clk);
         if (get_tx(k) === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = get_tx(k);
            end
            repeat (CPB) @(negedge clk);
            stop_bit = get_tx(k);
            check_tx(k, b, stop_bit);
         end
      end
   endtask

   initial tx_mon(0);
   initial tx_mon(1);

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int k, input logic v);
      if (k == 0) rx_a = v;
      else        rx_b = v;
   endtask

   task automatic send_byte(input int k, input logic [7:0] b, input logic stop_bit);
      tick(1);
      set_rx(k, 1'b0);
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         set_rx(k, b[i]);
         tick(CPB);
      end
      set_rx(k, stop_bit);
      tick(CPB);
      set_rx(k, 1'b1);
      tick(2 * CPB);
   endtask

   task automatic send_frame(input int k);
      foreach (frame_q[i]) send_byte(k, frame_q[i], 1'b1);
   endtask

   task automatic wait_idle(input int k, input int max_cyc);
      int n = 0;
      @(negedge clk);
      while (get_busy(k) && (n < max_cyc)) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (get_busy(k)) begin
         bad++;
         $display("FAIL idle wait dut=%0d: busy still 1 after %0d cycles, expected 0", k, max_cyc);
      end
   endtask

   initial begin
      rst  = 1'b0;
      rx_a = 1'b1;
      rx_b = 1'b1;
      tick(5);
      check("reset tx",   {31'd0, tx_a},   32'd1);
      check("reset wren", {31'd0, wren_a}, 32'd0);
      check("reset busy", {31'd0, busy_a}, 32'd0);
      check("reset err",  {31'd0, err_a},  32'd0);
      check("reset PADD", {16'd0, padd_a}, 32'd0);
      check("reset DOUT", {16'd0, dout_a}, 32'd0);
      rst = 1'b1;
      tick(4);

      // Two words, good checksum: 02+01+00+34+12+78+56 = 0x117 -> 0x17.
      wr_q.push_back({1'b0, 16'h0100, 16'h1234});
      wr_q.push_back({1'b0, 16'h0101, 16'h5678});
      tx_q.push_back({1'b0, 8'h06});
      frame_q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h17};
      send_frame(0);
      wait_idle(0, 2000);
      check("ack err", {31'd0, err_a}, 32'd0);

      // Same frame with a wrong checksum 0x1E: writes still happen, NAK, err set.
      wr_q.push_back({1'b0, 16'h0100, 16'h1234});
      wr_q.push_back({1'b0, 16'h0101, 16'h5678});
      tx_q.push_back({1'b0, 8'h15});
      frame_q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h1E};
      send_frame(0);
      wait_idle(0, 2000);
      check("nak err", {31'd0, err_a}, 32'd1);

      // A lone sync clears err and raises busy; silence then times the frame out.
      send_byte(0, 8'hA5, 1'b1);
      check("sync clears err", {31'd0, err_a},  32'd0);
      check("sync sets busy",  {31'd0, busy_a}, 32'd1);
      wait_idle(0, 1000);
      check("lone sync timeout err", {31'd0, err_a}, 32'd1);

      // 8-bit address instance: 02+00+FF+AA+55+01+00 = 0x201 -> 0x01; address wraps.
      wr_q.push_back({1'b1, 16'h00FF, 16'h55AA});
      wr_q.push_back({1'b1, 16'h0000, 16'h0001});
      tx_q.push_back({1'b1, 8'h06});
      frame_q = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hAA, 8'h55, 8'h01, 8'h00, 8'h01};
      send_frame(1);
      wait_idle(1, 2000);
      check("wrap err", {31'd0, err_b}, 32'd0);

      // Three words announced, only one sent, then silence: one write, abort, no TX.
      wr_q.push_back({1'b0, 16'h0010, 16'h2211});
      frame_q = '{8'hA5, 8'h03, 8'h00, 8'h10, 8'h11, 8'h22};
      send_frame(0);
      check("timeout busy mid", {31'd0, busy_a}, 32'd1);
      wait_idle(0, 1000);
      check("timeout err", {31'd0, err_a}, 32'd1);
      tick(4 * CPB * 10);
      check("timeout no extra write", wr_q.size(), 32'd0);

      // Framing error on a data byte aborts; the following frame is accepted.
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h20};
      send_frame(0);
      send_byte(0, 8'h77, 1'b0);
      check("ferr busy", {31'd0, busy_a}, 32'd0);
      check("ferr err",  {31'd0, err_a},  32'd1);
      // 01+00+30+CD+AB = 0x1A9 -> 0xA9.
      wr_q.push_back({1'b0, 16'h0030, 16'hABCD});
      tx_q.push_back({1'b0, 8'h06});
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h30, 8'hCD, 8'hAB, 8'hA9};
      send_frame(0);
      wait_idle(0, 2000);
      check("after ferr err", {31'd0, err_a}, 32'd0);

      // Reset in the middle of a data byte.
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h40};
      send_frame(0);
      tick(1);
      rx_a = 1'b0;
      tick(CPB);
      rx_a = 1'b1;
      tick(CPB);
      rx_a = 1'b0;
      tick(CPB);
      rst = 1'b0;
      #2;
      check("midreset tx",   {31'd0, tx_a},   32'd1);
      check("midreset wren", {31'd0, wren_a}, 32'd0);
      check("midreset busy", {31'd0, busy_a}, 32'd0);
      check("midreset err",  {31'd0, err_a},  32'd0);
      check("midreset PADD", {16'd0, padd_a}, 32'd0);
      check("midreset DOUT", {16'd0, dout_a}, 32'd0);
      tick(3);
      rx_a = 1'b1;
      rst  = 1'b1;
      tick(12 * CPB);
      // 01+00+50+EF+BE = 0x1FE -> 0xFE.
      wr_q.push_back({1'b0, 16'h0050, 16'hBEEF});
      tx_q.push_back({1'b0, 8'h06});
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h50, 8'hEF, 8'hBE, 8'hFE};
      send_frame(0);
      wait_idle(0, 2000);
      check("post reset err", {31'd0, err_a}, 32'd0);

      tick(4 * CPB);
      check("writes drained", wr_q.size(), 32'd0);
      check("tx drained",     tx_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
